// File: rtl/pref_ar_issuer_pkg.sv
// Shared constants and FSM state type for the prefetch/master AR issuer.
package pref_ar_issuer_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PREF   = 3'd1;
    localparam logic [2:0] OP_MASTER = 3'd2;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BURST_LEN = 3'd1;
    localparam logic [2:0] ERR_FIFO_FULL = 3'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_M = 2'd1,
        ISSUE_P = 2'd2
    } ar_state_e;

endpackage

// File: rtl/pref_req_fifo.sv
// Small synchronous FIFO holding block-aligned prefetch addresses.
module pref_req_fifo #(
    parameter int unsigned LOG_DEPTH = 2,
    parameter int unsigned WIDTH     = 64
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q;
    logic [LOG_DEPTH-1:0] rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count_q == (LOG_DEPTH + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pref_ar_issuer.sv
// Arbitrates master AR requests against queued prefetch candidates onto one slave AR channel.
module pref_ar_issuer
    import pref_ar_issuer_pkg::*;
#(
    parameter int unsigned ADDR_BITS           = 64,
    parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
    parameter int unsigned BURST_LEN_WIDTH     = 8,
    parameter int unsigned LOG_QUEUE_SIZE      = 6,
    parameter int unsigned LOG_PREF_FIFO_DEPTH = 2,
    parameter int unsigned ID_WIDTH            = 4
) (
    input  logic                       clk,
    input  logic                       resetN,

    input  logic                       prefValid,
    input  logic [ADDR_BITS-1:0]       prefAddr,
    output logic                       prefReady,

    input  logic                       m_arvalid,
    input  logic [ADDR_BITS-1:0]       m_araddr,
    input  logic [BURST_LEN_WIDTH-1:0] m_arlen,
    input  logic [ID_WIDTH-1:0]        m_arid,
    output logic                       m_arready,

    output logic                       s_arvalid,
    output logic [ADDR_BITS-1:0]       s_araddr,
    output logic [BURST_LEN_WIDTH-1:0] s_arlen,
    output logic [ID_WIDTH-1:0]        s_arid,
    input  logic                       s_arready,

    input  logic                       crs_enable,
    input  logic [BURST_LEN_WIDTH-1:0] crs_burstLen,
    input  logic [LOG_QUEUE_SIZE:0]    crs_maxOutstanding,
    input  logic [ID_WIDTH-1:0]        crs_prefId,

    input  logic                       almostFull,
    input  logic [LOG_QUEUE_SIZE:0]    outstandingReqCnt,

    output logic [2:0]                 queueOpcode,
    output logic [ADDR_BITS-1:0]       queueAddr,
    output logic [2:0]                 errorCode,
    output logic [15:0]                prefDropCnt
);

    localparam logic [ADDR_BITS-1:0] BLOCK_MASK =
        {{(ADDR_BITS - LOG_BLOCK_DATA_BYTES){1'b1}}, {LOG_BLOCK_DATA_BYTES{1'b0}}};

    ar_state_e                  state_q, state_d;
    logic [ADDR_BITS-1:0]       ar_addr_q, ar_addr_d;
    logic [BURST_LEN_WIDTH-1:0] ar_len_q, ar_len_d;
    logic [ID_WIDTH-1:0]        ar_id_q, ar_id_d;

    logic [2:0]                 opcode_q, opcode_d;
    logic [ADDR_BITS-1:0]       qaddr_q;
    logic [2:0]                 error_q, error_d;
    logic [15:0]                drop_cnt_q;
    logic [ADDR_BITS-1:0]       last_addr_q;
    logic                       last_valid_q;

    logic [ADDR_BITS-1:0]       aligned_addr;
    logic [ADDR_BITS-1:0]       fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic                       fifo_push;
    logic                       dup_drop;
    logic                       full_drop;
    logic                       pref_drop;
    logic                       pref_ok;
    logic                       master_cap;
    logic                       handshake;
    logic [BURST_LEN_WIDTH-1:0] pref_len;

    assign prefReady    = 1'b1;
    assign m_arready    = (state_q == IDLE);
    assign s_arvalid    = (state_q != IDLE);
    assign s_araddr     = ar_addr_q;
    assign s_arlen      = ar_len_q;
    assign s_arid       = ar_id_q;
    assign queueOpcode  = opcode_q;
    assign queueAddr    = qaddr_q;
    assign errorCode    = error_q;
    assign prefDropCnt  = drop_cnt_q;

    assign handshake    = s_arvalid && s_arready;
    assign pref_len     = crs_burstLen - BURST_LEN_WIDTH'(1);
    assign aligned_addr = prefAddr & BLOCK_MASK;
    assign pref_ok      = !fifo_empty && crs_enable && !almostFull
                          && (outstandingReqCnt < crs_maxOutstanding);

    // Duplicate suppression wins over the full check so repeats never raise an error.
    assign dup_drop  = prefValid && last_valid_q && (aligned_addr == last_addr_q);
    assign full_drop = prefValid && !dup_drop && fifo_full && !fifo_pop;
    assign pref_drop = dup_drop || full_drop;
    assign fifo_push = prefValid && !pref_drop;

    pref_req_fifo #(
        .LOG_DEPTH (LOG_PREF_FIFO_DEPTH),
        .WIDTH     (ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push      (fifo_push),
        .push_data (aligned_addr),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_id_d    = ar_id_q;
        fifo_pop   = 1'b0;
        master_cap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_arvalid) begin
                    master_cap = 1'b1;
                    ar_addr_d  = m_araddr;
                    ar_len_d   = m_arlen;
                    ar_id_d    = m_arid;
                    state_d    = ISSUE_M;
                end else if (pref_ok) begin
                    fifo_pop  = 1'b1;
                    ar_addr_d = fifo_head;
                    ar_len_d  = pref_len;
                    ar_id_d   = crs_prefId;
                    state_d   = ISSUE_P;
                end
            end
            ISSUE_M, ISSUE_P: begin
                if (s_arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opcode_d = OP_NOP;
        if (handshake) begin
            opcode_d = (state_q == ISSUE_M) ? OP_MASTER : OP_PREF;
        end
        error_d = ERR_NONE;
        if (master_cap && (m_arlen != pref_len)) begin
            error_d = ERR_BURST_LEN;
        end else if (full_drop) begin
            error_d = ERR_FIFO_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= IDLE;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_id_q      <= '0;
            opcode_q     <= OP_NOP;
            qaddr_q      <= '0;
            error_q      <= ERR_NONE;
            drop_cnt_q   <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_id_q   <= ar_id_d;
            opcode_q  <= opcode_d;
            error_q   <= error_d;
            if (handshake) begin
                qaddr_q <= ar_addr_q;
            end
            if (pref_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (fifo_push) begin
                last_addr_q  <= aligned_addr;
                last_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pref_ar_issuer.sv
// Directed bench for pref_ar_issuer: master/prefetch issue, drops, backpressure, reset.
module tb_pref_ar_issuer;

    logic        clk;
    logic        resetN;
    logic        prefValid;
    logic [63:0] prefAddr;
    logic        prefReady;
    logic        m_arvalid;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arid;
    logic        m_arready;
    logic        s_arvalid;
    logic [63:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [3:0]  s_arid;
    logic        s_arready;
    logic        crs_enable;
    logic [7:0]  crs_burstLen;
    logic [6:0]  crs_maxOutstanding;
    logic [3:0]  crs_prefId;
    logic        almostFull;
    logic [6:0]  outstandingReqCnt;
    logic [2:0]  queueOpcode;
    logic [63:0] queueAddr;
    logic [2:0]  errorCode;
    logic [15:0] prefDropCnt;

    int tests;
    int fails;

    pref_ar_issuer dut (
        .clk                (clk),
        .resetN             (resetN),
        .prefValid          (prefValid),
        .prefAddr           (prefAddr),
        .prefReady          (prefReady),
        .m_arvalid          (m_arvalid),
        .m_araddr           (m_araddr),
        .m_arlen            (m_arlen),
        .m_arid             (m_arid),
        .m_arready          (m_arready),
        .s_arvalid          (s_arvalid),
        .s_araddr           (s_araddr),
        .s_arlen            (s_arlen),
        .s_arid             (s_arid),
        .s_arready          (s_arready),
        .crs_enable         (crs_enable),
        .crs_burstLen       (crs_burstLen),
        .crs_maxOutstanding (crs_maxOutstanding),
        .crs_prefId         (crs_prefId),
        .almostFull         (almostFull),
        .outstandingReqCnt  (outstandingReqCnt),
        .queueOpcode        (queueOpcode),
        .queueAddr          (queueAddr),
        .errorCode          (errorCode),
        .prefDropCnt        (prefDropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_addr;
        tests = 0;
        fails = 0;
        resetN = 1'b0;
        prefValid = 1'b0;
        prefAddr = '0;
        m_arvalid = 1'b0;
        m_araddr = '0;
        m_arlen = '0;
        m_arid = '0;
        s_arready = 1'b0;
        crs_enable = 1'b1;
        crs_burstLen = 8'd4;
        crs_maxOutstanding = 7'd16;
        crs_prefId = 4'h5;
        almostFull = 1'b0;
        outstandingReqCnt = 7'd0;

        // Reset state
        step();
        step();
        check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        check("rst_opcode", 64'(queueOpcode), 64'd0);
        check("rst_qaddr", queueAddr, 64'd0);
        check("rst_err", 64'(errorCode), 64'd0);
        check("rst_drop", 64'(prefDropCnt), 64'd0);
        check("rst_m_arready", 64'(m_arready), 64'd1);
        check("pref_ready", 64'(prefReady), 64'd1);
        resetN = 1'b1;
        step();

        // Master-only request
        s_arready = 1'b1;
        m_arvalid = 1'b1;
        m_araddr = 64'h1000;
        m_arlen = 8'd3;
        m_arid = 4'h2;
        step();
        check("m_s_arvalid", 64'(s_arvalid), 64'd1);
        check("m_s_araddr", s_araddr, 64'h1000);
        check("m_s_arlen", 64'(s_arlen), 64'd3);
        check("m_s_arid", 64'(s_arid), 64'h2);
        check("m_arready_busy", 64'(m_arready), 64'd0);
        check("m_err", 64'(errorCode), 64'd0);
        m_arvalid = 1'b0;
        step();
        check("m_done_valid", 64'(s_arvalid), 64'd0);
        check("m_opcode", 64'(queueOpcode), 64'd2);
        check("m_qaddr", queueAddr, 64'h1000);
        step();
        check("m_opcode_pulse", 64'(queueOpcode), 64'd0);

        // Prefetch push with alignment and duplicate drop
        s_arready = 1'b0;
        prefValid = 1'b1;
        prefAddr = 64'h2047;
        step();
        prefAddr = 64'h2050;
        step();
        prefValid = 1'b0;
        check("p_s_arvalid", 64'(s_arvalid), 64'd1);
        check("p_s_araddr", s_araddr, 64'h2040);
        check("p_s_arlen", 64'(s_arlen), 64'd3);
        check("p_s_arid", 64'(s_arid), 64'h5);
        check("p_dup_drop", 64'(prefDropCnt), 64'd1);
        check("p_dup_silent", 64'(errorCode), 64'd0);
        s_arready = 1'b1;
        step();
        check("p_opcode", 64'(queueOpcode), 64'd1);
        check("p_qaddr", queueAddr, 64'h2040);
        step();
        check("p_fifo_empty", 64'(s_arvalid), 64'd0);

        // Contention: master wins over a pending prefetch
        s_arready = 1'b0;
        crs_enable = 1'b0;
        prefValid = 1'b1;
        prefAddr = 64'h3000;
        step();
        prefValid = 1'b0;
        step();
        check("c_enable_blocks", 64'(s_arvalid), 64'd0);
        crs_enable = 1'b1;
        m_arvalid = 1'b1;
        m_araddr = 64'h4000;
        m_arid = 4'h1;
        step();
        check("c_master_first", s_araddr, 64'h4000);
        check("c_master_id", 64'(s_arid), 64'h1);
        m_arvalid = 1'b0;
        s_arready = 1'b1;
        step();
        check("c_m_opcode", 64'(queueOpcode), 64'd2);
        check("c_idle_gap", 64'(s_arvalid), 64'd0);
        step();
        check("c_pref_valid", 64'(s_arvalid), 64'd1);
        check("c_pref_addr", s_araddr, 64'h3000);
        check("c_pref_id", 64'(s_arid), 64'h5);
        step();
        check("c_p_opcode", 64'(queueOpcode), 64'd1);
        check("c_p_qaddr", queueAddr, 64'h3000);

        // Backpressure for 5 cycles
        s_arready = 1'b0;
        m_arvalid = 1'b1;
        m_araddr = 64'h5000;
        m_arlen = 8'd3;
        m_arid = 4'h6;
        step();
        m_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 64'(s_arvalid), 64'd1);
            check("bp_addr", s_araddr, 64'h5000);
            check("bp_len", 64'(s_arlen), 64'd3);
            check("bp_id", 64'(s_arid), 64'h6);
            check("bp_no_opcode", 64'(queueOpcode), 64'd0);
        end
        s_arready = 1'b1;
        step();
        check("bp_opcode", 64'(queueOpcode), 64'd2);
        check("bp_qaddr", queueAddr, 64'h5000);
        step();
        check("bp_single_pulse", 64'(queueOpcode), 64'd0);
        check("bp_idle", 64'(s_arvalid), 64'd0);

        // Master burst length mismatch is forwarded with an error pulse
        m_arvalid = 1'b1;
        m_araddr = 64'h6000;
        m_arlen = 8'd7;
        m_arid = 4'h3;
        step();
        m_arvalid = 1'b0;
        check("len_err", 64'(errorCode), 64'd1);
        check("len_fwd", 64'(s_arlen), 64'd7);
        step();
        check("len_err_clear", 64'(errorCode), 64'd0);
        check("len_opcode", 64'(queueOpcode), 64'd2);

        // Overflow with throttle on
        almostFull = 1'b1;
        prefValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            prefAddr = 64'h7000 + 64'(i) * 64'h40;
            step();
            check("ovf_err", 64'(errorCode), (i == 4) ? 64'd2 : 64'd0);
        end
        check("ovf_drop", 64'(prefDropCnt), 64'd2);
        // Full drop and burst-length error in the same cycle
        prefAddr = 64'h7140;
        m_arvalid = 1'b1;
        m_araddr = 64'h8000;
        m_arlen = 8'd7;
        m_arid = 4'h0;
        step();
        check("prio_err", 64'(errorCode), 64'd1);
        check("prio_drop", 64'(prefDropCnt), 64'd3);
        m_arvalid = 1'b0;
        prefValid = 1'b0;
        step();
        check("prio_opcode", 64'(queueOpcode), 64'd2);
        check("prio_err_clear", 64'(errorCode), 64'd0);
        step();
        check("throttled", 64'(s_arvalid), 64'd0);
        almostFull = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 64'h7000 + 64'(k) * 64'h40;
            step();
            check("drain_addr", s_araddr, exp_addr);
            check("drain_valid", 64'(s_arvalid), 64'd1);
            step();
            check("drain_opcode", 64'(queueOpcode), 64'd1);
            check("drain_qaddr", queueAddr, exp_addr);
        end
        step();
        check("drain_empty", 64'(s_arvalid), 64'd0);

        // Push and pop together on a full FIFO
        almostFull = 1'b1;
        prefValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prefAddr = 64'h9000 + 64'(i) * 64'h40;
            step();
        end
        almostFull = 1'b0;
        prefAddr = 64'h9100;
        step();
        prefValid = 1'b0;
        check("pp_err", 64'(errorCode), 64'd0);
        check("pp_drop", 64'(prefDropCnt), 64'd3);
        check("pp_head", s_araddr, 64'h9000);
        step();
        for (int k = 1; k < 5; k++) begin
            exp_addr = 64'h9000 + 64'(k) * 64'h40;
            step();
            check("pp_addr", s_araddr, exp_addr);
            step();
            check("pp_opcode", 64'(queueOpcode), 64'd1);
        end
        step();
        check("pp_empty", 64'(s_arvalid), 64'd0);

        // Reset while a prefetch AR is stalled
        s_arready = 1'b0;
        prefValid = 1'b1;
        prefAddr = 64'hA000;
        step();
        prefAddr = 64'hA040;
        step();
        prefValid = 1'b0;
        check("rs_stalled", s_araddr, 64'hA000);
        resetN = 1'b0;
        step();
        check("rs_valid", 64'(s_arvalid), 64'd0);
        check("rs_opcode", 64'(queueOpcode), 64'd0);
        check("rs_drop", 64'(prefDropCnt), 64'd0);
        resetN = 1'b1;
        s_arready = 1'b1;
        step();
        check("rs_fifo_empty", 64'(s_arvalid), 64'd0);
        check("rs_no_pulse", 64'(queueOpcode), 64'd0);
        prefValid = 1'b1;
        prefAddr = 64'hA000;
        step();
        prefValid = 1'b0;
        step();
        check("rs_last_cleared", s_araddr, 64'hA000);
        check("rs_last_valid", 64'(s_arvalid), 64'd1);
        step();
        check("rs_opcode_after", 64'(queueOpcode), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
